// File: rtl/adder_arb_pkg.sv
// Shared parameters and helpers for the round-robin shared-adder block.
// Optional saturation is selected with ADDER_ARB_SAT_EN (see adder_arbiter.sv).
package adder_arb_pkg;

   localparam int unsigned DefWidth = 16;
   localparam int unsigned DefN     = 4;
   // Upper bound on requester count accepted by one_hot_to_idx.
   localparam int unsigned MaxN     = 32;

   function automatic int unsigned id_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned one_hot_to_idx(input logic [MaxN-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < int'(MaxN); i++) begin
         if (oh[i]) idx |= unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and result handshake bundle for adder_arbiter.
// master = requesters/consumer side, slave = the arbiter.
interface adder_arbiter_if #(
   parameter int unsigned WIDTH = adder_arb_pkg::DefWidth,
   parameter int unsigned N     = adder_arb_pkg::DefN
);
   localparam int unsigned IdW = adder_arb_pkg::id_w(N);

   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*WIDTH-1:0] req_a;
   logic [N*WIDTH-1:0] req_b;
   logic               resp_valid;
   logic               resp_ready;
   logic [WIDTH-1:0]   resp_data;
   logic               resp_carry;
   logic [IdW-1:0]     resp_id;
   logic [15:0]        op_count;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_carry, resp_id, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_carry, resp_id, op_count
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer moves past the winner only when advance=1.
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned N = DefN
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int unsigned IdW = id_w(N);

   logic [IdW-1:0] ptr_q, ptr_d;
   logic           found;
   int unsigned    gnt_idx;

   // Two passes: pointer..N-1 first, then the wrapped part 0..pointer-1.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i] && (i >= int'(ptr_q))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_idx = one_hot_to_idx(MaxN'(gnt));
      ptr_d   = ptr_q;
      if (advance) begin
         ptr_d = (gnt_idx >= N - 1) ? '0 : IdW'(gnt_idx + 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder among N requesters via round-robin arbitration.
// Define ADDER_ARB_SAT_EN to saturate the sum on carry-out (carry still reports raw).
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned N     = DefN
) (
   input logic            clk,
   input logic            reset,
   adder_arbiter_if.slave io
);

   localparam int unsigned ID_W = id_w(N);

   logic             can_accept;
   logic             accept;
   logic [N-1:0]     gnt;
   logic [WIDTH-1:0] a_arr [N];
   logic [WIDTH-1:0] b_arr [N];
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sum_data;
   logic [ID_W-1:0]  win_id;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             carry_q, carry_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [15:0]      count_q, count_d;

   rr_arbiter #(
      .N (N)
   ) u_rr_arbiter (
      .clk     (clk),
      .reset   (reset),
      .req     (io.req_valid),
      .advance (accept),
      .gnt     (gnt)
   );

   for (genvar g = 0; g < int'(N); g++) begin : g_unpack
      assign a_arr[g] = io.req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = io.req_b[g*WIDTH +: WIDTH];
   end

   assign can_accept   = !valid_q || io.resp_ready;
   assign io.req_ready = gnt & {N{can_accept}};
   // gnt only ever selects a valid requester, so any grant plus a free slot is an accept.
   assign accept       = (|gnt) && can_accept;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (gnt[i]) begin
            a_sel |= a_arr[i];
            b_sel |= b_arr[i];
         end
      end
   end

   assign sum    = {1'b0, a_sel} + {1'b0, b_sel};
   assign win_id = ID_W'(one_hot_to_idx(MaxN'(gnt)));

`ifdef ADDER_ARB_SAT_EN
   assign sum_data = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
   assign sum_data = sum[WIDTH-1:0];
`endif

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      carry_d = carry_q;
      id_d    = id_q;
      count_d = count_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = sum_data;
         carry_d = sum[WIDTH];
         id_d    = win_id;
         count_d = count_q + 16'd1;
      end else if (io.resp_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         carry_q <= 1'b0;
         id_q    <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         id_q    <= id_d;
         count_q <= count_d;
      end
   end

   assign io.resp_valid = valid_q;
   assign io.resp_data  = data_q;
   assign io.resp_carry = carry_q;
   assign io.resp_id    = id_q;
   assign io.op_count   = count_q;

endmodule
